// File: rtl/muldiv_seq_pkg.sv
// Shared types and op codes for the multiply/divide sequencer.
// Consumers: muldiv_seq, muldiv_step and the bench.
package muldiv_seq_pkg;

  localparam int CPU_MULDIVOP_WIDTH = 3;

  localparam logic [CPU_MULDIVOP_WIDTH-1:0] CPU_MULDIVOP_NONE  = 3'd0;
  localparam logic [CPU_MULDIVOP_WIDTH-1:0] CPU_MULDIVOP_MULT  = 3'd1;
  localparam logic [CPU_MULDIVOP_WIDTH-1:0] CPU_MULDIVOP_MULTU = 3'd2;
  localparam logic [CPU_MULDIVOP_WIDTH-1:0] CPU_MULDIVOP_DIV   = 3'd3;
  localparam logic [CPU_MULDIVOP_WIDTH-1:0] CPU_MULDIVOP_DIVU  = 3'd4;
  localparam logic [CPU_MULDIVOP_WIDTH-1:0] CPU_MULDIVOP_MTHI  = 3'd5;
  localparam logic [CPU_MULDIVOP_WIDTH-1:0] CPU_MULDIVOP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } step_mode_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply (multiplier in lo, product
// grows into hi) or restoring divide (dividend shifts out of lo, quotient in).
module muldiv_step
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  step_mode_e       mode,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  // The top bit of diff_s is the borrow: set only when the divisor does not fit.
  always_comb begin
    sum_s     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
    shifted_s = {hi_i, lo_i[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, opnd_i};
    hi_o      = hi_i;
    lo_o      = lo_i;
    case (mode)
      MODE_MUL: begin
        hi_o = sum_s[WIDTH:1];
        lo_o = {sum_s[0], lo_i[WIDTH-1:1]};
      end
      MODE_DIV: begin
        if (!diff_s[WIDTH]) begin
          hi_o = diff_s[WIDTH-1:0];
          lo_o = {lo_i[WIDTH-2:0], 1'b1};
        end else begin
          hi_o = shifted_s[WIDTH-1:0];
          lo_o = {lo_i[WIDTH-2:0], 1'b0};
        end
      end
      default: begin
        hi_o = hi_i;
        lo_o = lo_i;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with MTHI/MTLO writes.
// Define CPU_MULDIV_RADIX4_EN to retire two multiplier bits per RUN cycle.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CPU_MULDIVOP_WIDTH-1:0] op,
  input  logic                          start,
  input  logic                          cancel,
  input  logic [WIDTH-1:0]              a,
  input  logic [WIDTH-1:0]              b,
  output logic                          busy,
  output logic [WIDTH-1:0]              hi,
  output logic [WIDTH-1:0]              lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] N_DIV = CNT_W'(WIDTH);
`ifdef CPU_MULDIV_RADIX4_EN
  localparam logic [CNT_W-1:0] N_MUL = CNT_W'(WIDTH / 2);
`else
  localparam logic [CNT_W-1:0] N_MUL = CNT_W'(WIDTH);
`endif

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  state_e           state_q, state_d;
  step_mode_e       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d, a_q, a_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             neg_q, neg_d, rem_neg_q, rem_neg_d, div0_q, div0_d;
  logic             busy_q, busy_d;

  logic             is_signed_s, sa_s, sb_s;
  logic [WIDTH-1:0] mag_a_s, mag_b_s;
  logic [WIDTH-1:0] s0_hi_s, s0_lo_s, step_hi_s, step_lo_s;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;

  assign is_signed_s = (op == CPU_MULDIVOP_MULT) || (op == CPU_MULDIVOP_DIV);
  assign sa_s        = is_signed_s & a[WIDTH-1];
  assign sb_s        = is_signed_s & b[WIDTH-1];
  assign mag_a_s     = sa_s ? neg_w(a) : a;
  assign mag_b_s     = sb_s ? neg_w(b) : b;
  assign prod_s      = {acc_hi_q, acc_lo_q};
  assign prod_fix_s  = neg_q ? (~prod_s + (2*WIDTH)'(1)) : prod_s;

  muldiv_step #(.WIDTH(WIDTH)) u_step0 (
    .mode   (mode_q),
    .hi_i   (acc_hi_q),
    .lo_i   (acc_lo_q),
    .opnd_i (opnd_q),
    .hi_o   (s0_hi_s),
    .lo_o   (s0_lo_s)
  );

`ifdef CPU_MULDIV_RADIX4_EN
  logic [WIDTH-1:0] s1_hi_s, s1_lo_s;

  muldiv_step #(.WIDTH(WIDTH)) u_step1 (
    .mode   (mode_q),
    .hi_i   (s0_hi_s),
    .lo_i   (s0_lo_s),
    .opnd_i (opnd_q),
    .hi_o   (s1_hi_s),
    .lo_o   (s1_lo_s)
  );

  // Divide keeps radix 2; only multiply consumes the second stage.
  assign step_hi_s = (mode_q == MODE_MUL) ? s1_hi_s : s0_hi_s;
  assign step_lo_s = (mode_q == MODE_MUL) ? s1_lo_s : s0_lo_s;
`else
  assign step_hi_s = s0_hi_s;
  assign step_lo_s = s0_lo_s;
`endif

  // Next-state, datapath and HI/LO update.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    a_d       = a_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !cancel) begin
          case (op)
            CPU_MULDIVOP_MULT, CPU_MULDIVOP_MULTU: begin
              mode_d    = MODE_MUL;
              acc_hi_d  = '0;
              acc_lo_d  = mag_b_s;
              opnd_d    = mag_a_s;
              cnt_d     = N_MUL;
              neg_d     = sa_s ^ sb_s;
              rem_neg_d = 1'b0;
              div0_d    = 1'b0;
              a_d       = a;
              state_d   = ST_RUN;
            end
            CPU_MULDIVOP_DIV, CPU_MULDIVOP_DIVU: begin
              mode_d    = MODE_DIV;
              acc_hi_d  = '0;
              acc_lo_d  = mag_a_s;
              opnd_d    = mag_b_s;
              cnt_d     = N_DIV;
              neg_d     = sa_s ^ sb_s;
              rem_neg_d = sa_s;
              div0_d    = (b == '0);
              a_d       = a;
              state_d   = ST_RUN;
            end
            CPU_MULDIVOP_MTHI: hi_d = a;
            CPU_MULDIVOP_MTLO: lo_d = a;
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          acc_hi_d = step_hi_s;
          acc_lo_d = step_lo_s;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_FIX;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (cancel) begin
          hi_d = hi_q;
        end else if (mode_q == MODE_MUL) begin
          hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
          lo_d = prod_fix_s[WIDTH-1:0];
        end else if (div0_q) begin
          hi_d = a_q;
          lo_d = {WIDTH{1'b1}};
        end else begin
          hi_d = rem_neg_q ? neg_w(acc_hi_q) : acc_hi_q;
          lo_d = neg_q ? neg_w(acc_lo_q) : acc_lo_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_MUL;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      a_q       <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      a_q       <= a_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: arithmetic vectors, MTHI/MTLO, hazards,
// cancel and reset. Follows CPU_MULDIV_RADIX4_EN for the expected multiply latency.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  localparam int W = 32;
`ifdef CPU_MULDIV_RADIX4_EN
  localparam int MUL_BUSY = 17;
`else
  localparam int MUL_BUSY = 33;
`endif
  localparam int DIV_BUSY = 33;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    op = CPU_MULDIVOP_NONE;
  logic          start = 1'b0;
  logic          cancel = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy;
  logic [W-1:0]  hi, lo;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [31:0] a, b, hi, lo;
    int         busy_cyc;
  } vec_t;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .op(op), .start(start), .cancel(cancel),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Issue one op for a single cycle, then count busy cycles until it drops.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int cyc);
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = CPU_MULDIVOP_NONE;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++; if (hi !== 32'h0) begin n_err++; $display("FAIL reset_hi got=%h exp=0", hi); end
    n_vec++; if (lo !== 32'h0) begin n_err++; $display("FAIL reset_lo got=%h exp=0", lo); end
    rst = 1'b0;
  endtask

  task automatic test_arith();
    vec_t v[15];
    int cyc;
    v = '{
      '{"mult_neg2x3",   CPU_MULDIVOP_MULT,  32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, MUL_BUSY},
      '{"multu_max",     CPU_MULDIVOP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_BUSY},
      '{"div_m7_2",      CPU_MULDIVOP_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_BUSY},
      '{"divu_7_0",      CPU_MULDIVOP_DIVU,  32'h7,        32'h0,        32'h00000007, 32'hFFFFFFFF, DIV_BUSY},
      '{"div_ovf",       CPU_MULDIVOP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_BUSY},
      '{"div_m5_0",      CPU_MULDIVOP_DIV,   32'hFFFFFFFB, 32'h0,        32'hFFFFFFFB, 32'hFFFFFFFF, DIV_BUSY},
      '{"div_7_m2",      CPU_MULDIVOP_DIV,   32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_BUSY},
      '{"div_m7_m2",     CPU_MULDIVOP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, DIV_BUSY},
      '{"divu_100_7",    CPU_MULDIVOP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, DIV_BUSY},
      '{"divu_max_1",    CPU_MULDIVOP_DIVU,  32'hFFFFFFFF, 32'h1,        32'h00000000, 32'hFFFFFFFF, DIV_BUSY},
      '{"divu_big",      CPU_MULDIVOP_DIVU,  32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'h00000001, DIV_BUSY},
      '{"mult_min_sq",   CPU_MULDIVOP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MUL_BUSY},
      '{"multu_shift",   CPU_MULDIVOP_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, MUL_BUSY},
      '{"mult_7_m1",     CPU_MULDIVOP_MULT,  32'h7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, MUL_BUSY},
      '{"mult_m1_0",     CPU_MULDIVOP_MULT,  32'hFFFFFFFF, 32'h0,        32'h00000000, 32'h00000000, MUL_BUSY}
    };
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, cyc);
      n_vec++; if (cyc != v[i].busy_cyc) begin n_err++; $display("FAIL %s_busy got=%0d exp=%0d", v[i].name, cyc, v[i].busy_cyc); end
      n_vec++; if (hi !== v[i].hi) begin n_err++; $display("FAIL %s_hi got=%h exp=%h", v[i].name, hi, v[i].hi); end
      n_vec++; if (lo !== v[i].lo) begin n_err++; $display("FAIL %s_lo got=%h exp=%h", v[i].name, lo, v[i].lo); end
    end
  endtask

  task automatic test_mthi_mtlo();
    int cyc;
    run_op(CPU_MULDIVOP_MTHI, 32'h1234, 32'h0, cyc);
    n_vec++; if (cyc != 0) begin n_err++; $display("FAIL mthi_busy got=%0d exp=0", cyc); end
    n_vec++; if (hi !== 32'h1234) begin n_err++; $display("FAIL mthi_hi got=%h exp=1234", hi); end
    run_op(CPU_MULDIVOP_MTLO, 32'h55, 32'h0, cyc);
    n_vec++; if (lo !== 32'h55) begin n_err++; $display("FAIL mtlo_lo got=%h exp=55", lo); end
    n_vec++; if (hi !== 32'h1234) begin n_err++; $display("FAIL mtlo_hi_kept got=%h exp=1234", hi); end
    run_op(CPU_MULDIVOP_NONE, 32'hAAAA, 32'hBBBB, cyc);
    repeat (2) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL none_busy got=%b exp=0", busy); end
    n_vec++; if (hi !== 32'h1234 || lo !== 32'h55) begin n_err++; $display("FAIL none_hilo got=%h/%h exp=1234/55", hi, lo); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    op = CPU_MULDIVOP_MULT; a = 32'hFFFFFFFE; b = 32'h3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = CPU_MULDIVOP_NONE;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      start = (cyc == 3 || cyc == 4);
      op    = (cyc == 3) ? CPU_MULDIVOP_MULTU : ((cyc == 4) ? CPU_MULDIVOP_MTHI : CPU_MULDIVOP_NONE);
      a     = (cyc == 3) ? 32'hFFFFFFFF : 32'hDEAD;
      b     = 32'hFFFFFFFF;
      @(negedge clk);
    end
    start = 1'b0; op = CPU_MULDIVOP_NONE;
    n_vec++; if (cyc != MUL_BUSY) begin n_err++; $display("FAIL b2b_busy got=%0d exp=%0d", cyc, MUL_BUSY); end
    n_vec++; if (hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL b2b_hi got=%h exp=ffffffff", hi); end
    n_vec++; if (lo !== 32'hFFFFFFFA) begin n_err++; $display("FAIL b2b_lo got=%h exp=fffffffa", lo); end
    repeat (2) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_no_restart got=%b exp=0", busy); end
  endtask

  task automatic test_cancel();
    int cyc;
    run_op(CPU_MULDIVOP_MTHI, 32'h77, 32'h0, cyc);
    run_op(CPU_MULDIVOP_MTLO, 32'h55, 32'h0, cyc);
    n_vec++; if (lo !== 32'h55) begin n_err++; $display("FAIL cancel_pre_lo got=%h exp=55", lo); end
    // Cancel in cycle t+10 of a multiply.
    @(negedge clk);
    op = CPU_MULDIVOP_MULT; a = 32'h7; b = 32'h3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = CPU_MULDIVOP_NONE;
    for (int i = 1; i < 10; i++) @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL cancel_run_busy_before got=%b exp=1", busy); end
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL cancel_run_busy got=%b exp=0", busy); end
    repeat (3) @(negedge clk);
    n_vec++; if (lo !== 32'h55 || hi !== 32'h77) begin n_err++; $display("FAIL cancel_run_hilo got=%h/%h exp=77/55", hi, lo); end
    // Cancel blocks an MTHI issued in IDLE.
    op = CPU_MULDIVOP_MTHI; a = 32'hBEEF; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; op = CPU_MULDIVOP_NONE;
    @(negedge clk);
    n_vec++; if (hi !== 32'h77) begin n_err++; $display("FAIL cancel_idle_mthi got=%h exp=77", hi); end
    // Cancel coinciding with the FIX write.
    op = CPU_MULDIVOP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = CPU_MULDIVOP_NONE;
    for (int i = 1; i < DIV_BUSY; i++) @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL cancel_fix_busy_before got=%b exp=1", busy); end
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL cancel_fix_busy got=%b exp=0", busy); end
    n_vec++; if (lo !== 32'h55 || hi !== 32'h77) begin n_err++; $display("FAIL cancel_fix_hilo got=%h/%h exp=77/55", hi, lo); end
    // A clean op afterwards still completes.
    run_op(CPU_MULDIVOP_DIVU, 32'd100, 32'd7, cyc);
    n_vec++; if (cyc != DIV_BUSY || lo !== 32'hE || hi !== 32'h2) begin n_err++; $display("FAIL cancel_recover got=%0d %h/%h exp=%0d 2/e", cyc, hi, lo, DIV_BUSY); end
  endtask

  task automatic test_rst_mid_run();
    @(negedge clk);
    op = CPU_MULDIVOP_MULT; a = 32'h5; b = 32'h6; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = CPU_MULDIVOP_NONE;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    n_vec++; if (hi !== 32'h0 || lo !== 32'h0) begin n_err++; $display("FAIL rst_mid_hilo got=%h/%h exp=0/0", hi, lo); end
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_stays_idle got=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_mthi_mtlo();
    test_back_to_back();
    test_cancel();
    test_rst_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
